// File: rtl/lzw_dict_matcher_if.sv
// lzw_dict_matcher_if: dictionary RAM read port between the matcher and the RAM
// Signals:
//   ram_rd      one-cycle read strobe (master -> RAM)
//   ram_addr    read address, valid while ram_rd=1
//   ram_rdata   read data, valid with ram_rvalid (RAM -> master)
//   ram_rvalid  read return, one or more cycles after ram_rd
interface lzw_dict_matcher_if #(
    parameter int ADDR_W = 18,
    parameter int RAM_W  = 16
);
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic [RAM_W-1:0]  ram_rdata;
    logic              ram_rvalid;
    modport master (output ram_rd, ram_addr, input ram_rdata, ram_rvalid);
    modport slave  (input ram_rd, ram_addr, output ram_rdata, ram_rvalid);
endinterface

// File: rtl/lzw_dict_matcher.sv
// lzw_dict_matcher: LZW dictionary search engine walking entries from a base pointer to the insert pointer
// Ports:
//   Clk, Reset_n              clock (rising edge), asynchronous active-low reset
//   string_clear, char_push   string edit ops (IDLE only, clear wins over push)
//   char_in                   character appended on char_push
//   search_start              start a search (IDLE only)
//   search_base, insert_ptr   first entry address / exclusive end, sampled on search_start
//   ram                       dictionary RAM read port (master side)
//   busy, done                search in progress / one-cycle end pulse
//   found, match_code         result of the last search, held until the next one ends
//   string_len, overflow      current length / sticky dropped-push flag
// Optional feature: define LZW_ROOT_SHORTCUT_EN to answer single-character strings without
// touching the RAM (the root code is the character itself).
module lzw_dict_matcher #(
    parameter int CHAR_W     = 8,
    parameter int MAX_CHARS  = 16,
    parameter int RAM_W      = 16,
    parameter int ADDR_W     = 18,
    parameter int CODE_W     = 12,
    parameter int FIRST_CODE = 256
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             string_clear,
    input  logic                             char_push,
    input  logic [CHAR_W-1:0]                char_in,
    input  logic                             search_start,
    input  logic [ADDR_W-1:0]                search_base,
    input  logic [ADDR_W-1:0]                insert_ptr,
    lzw_dict_matcher_if.master               ram,
    output logic                             busy,
    output logic                             done,
    output logic                             found,
    output logic [CODE_W-1:0]                match_code,
    output logic [$clog2(MAX_CHARS+1)-1:0]   string_len,
    output logic                             overflow
);
    localparam int CPW   = RAM_W / CHAR_W;
    localparam int LEN_W = $clog2(MAX_CHARS + 1);
    localparam int IDX_W = $clog2(MAX_CHARS);

    typedef enum logic [1:0] {IDLE, HDR, DATA, FIN} stateType;

    stateType          state, stateNext;
    logic [ADDR_W-1:0] ptr, ptrNext, insertEnd, insertEndNext;
    logic [CODE_W-1:0] code, codeNext, codeReg, resCode;
    logic [LEN_W-1:0]  wordIdx, wordIdxNext, strLen;
    logic [CHAR_W-1:0] strChars [MAX_CHARS];
    logic              pending, foundReg, resFound, overflowReg;
    logic              rdStrobe, readBack, lenHit, wordMatch, lastWord, strOp, pushOk;
    logic [ADDR_W-1:0] rdAddr, hdrSkip, strWords;
    logic [7:0]        entryLen;

    assign entryLen = ram.ram_rdata[7:0];
    assign readBack = pending && ram.ram_rvalid;
    assign lenHit   = int'(entryLen) == int'(strLen);
    // words occupied by an entry's data (ceil(L/CPW))
    assign hdrSkip  = ADDR_W'((int'(entryLen) + CPW - 1) / CPW);
    assign strWords = ADDR_W'((int'(strLen) + CPW - 1) / CPW);
    assign lastWord = (int'(wordIdx) + 1) * CPW >= int'(strLen);

    // only chars still inside the string are compared; pad chars of the last word are don't-care
    always_comb begin
        wordMatch = 1'b1;
        for (int k = 0; k < CPW; k++)
            if (int'(wordIdx) * CPW + k < int'(strLen))
                wordMatch = wordMatch &
                    (ram.ram_rdata[k*CHAR_W +: CHAR_W] == strChars[IDX_W'(int'(wordIdx) * CPW + k)]);
    end

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) state <= IDLE;
        else          state <= stateNext;

    always_comb begin
        stateNext     = state;
        ptrNext       = ptr;
        insertEndNext = insertEnd;
        codeNext      = code;
        wordIdxNext   = wordIdx;
        resFound      = foundReg;
        resCode       = codeReg;
        rdStrobe      = 1'b0;
        rdAddr        = '0;
        case (state)
            IDLE: if (search_start) begin
                insertEndNext = insert_ptr;
                if (strLen == '0) begin
                    stateNext = FIN;
                    resFound  = 1'b0;
                    resCode   = '0;
                end
`ifdef LZW_ROOT_SHORTCUT_EN
                else if (strLen == LEN_W'(1)) begin
                    stateNext = FIN;
                    resFound  = 1'b1;
                    resCode   = CODE_W'(strChars[0]);
                end
`endif
                else begin
                    ptrNext   = search_base;
                    codeNext  = CODE_W'(FIRST_CODE);
                    stateNext = HDR;
                end
            end
            HDR: if (readBack) begin
                if (lenHit) begin
                    wordIdxNext = '0;
                    stateNext   = DATA;
                end else begin
                    ptrNext  = ptr + ADDR_W'(1) + hdrSkip;
                    codeNext = code + CODE_W'(1);
                end
            end else if (!pending) begin
                // end of dictionary is an equality test only, so the walk may wrap the address space
                if (ptr == insertEnd) begin
                    stateNext = FIN;
                    resFound  = 1'b0;
                    resCode   = '0;
                end else begin
                    rdStrobe = 1'b1;
                    rdAddr   = ptr;
                end
            end
            DATA: if (readBack) begin
                if (!wordMatch) begin
                    ptrNext   = ptr + ADDR_W'(1) + strWords;
                    codeNext  = code + CODE_W'(1);
                    stateNext = HDR;
                end else if (lastWord) begin
                    stateNext = FIN;
                    resFound  = 1'b1;
                    resCode   = code;
                end else wordIdxNext = wordIdx + LEN_W'(1);
            end else if (!pending) begin
                rdStrobe = 1'b1;
                rdAddr   = ptr + ADDR_W'(1) + ADDR_W'(wordIdx);
            end
            default: stateNext = IDLE;
        endcase
    end

    assign strOp  = state == IDLE && !search_start;
    assign pushOk = strOp && !string_clear && char_push && strLen != LEN_W'(MAX_CHARS);

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            ptr         <= '0;
            insertEnd   <= '0;
            code        <= '0;
            wordIdx     <= '0;
            pending     <= 1'b0;
            foundReg    <= 1'b0;
            codeReg     <= '0;
            strLen      <= '0;
            overflowReg <= 1'b0;
        end else begin
            ptr       <= ptrNext;
            insertEnd <= insertEndNext;
            code      <= codeNext;
            wordIdx   <= wordIdxNext;
            // a return with nothing outstanding is simply dropped
            pending   <= rdStrobe || (pending && !ram.ram_rvalid);
            foundReg  <= resFound;
            codeReg   <= resCode;
            if (strOp && string_clear) begin
                strLen      <= '0;
                overflowReg <= 1'b0;
            end else if (pushOk) strLen <= strLen + LEN_W'(1);
            else if (strOp && char_push) overflowReg <= 1'b1;
        end

    always_ff @(posedge Clk)
        if (pushOk) strChars[strLen[IDX_W-1:0]] <= char_in;

    assign ram.ram_rd   = rdStrobe;
    assign ram.ram_addr = rdAddr;
    assign busy         = state != IDLE;
    assign done         = state == FIN;
    assign found        = foundReg;
    assign match_code   = codeReg;
    assign string_len   = strLen;
    assign overflow     = overflowReg;
endmodule
